// File: rtl/option_menu_ctrl.sv
// Option menu controller: cursor tracking with auto-repeat and wrap-around,
// mapping of draw coordinates onto four stacked option sprite boxes, and a
// valid/ready handoff of the confirmed choice to the game FSM.
module option_menu_ctrl #(
   parameter int BOX_W      = 150,
   parameter int BOX_H      = 60,
   parameter int BOX_X0     = 245,
   parameter int BOX_Y0     = 90,
   parameter int BOX_GAP    = 15,
   parameter int REPEAT_CYC = 12500000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        menu_en,
   input  logic        key_up,
   input  logic        key_down,
   input  logic        key_sel,
   input  logic [9:0]  draw_x,
   input  logic [9:0]  draw_y,
   output logic [1:0]  option,
   output logic [1:0]  option_ctr,
   output logic [13:0] read_address,
   output logic        pix_in_box,
   output logic        choice_valid,
   output logic [1:0]  choice,
   input  logic        choice_ready
);

   localparam int CNT_W = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC + 1) : 1;
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYC - 1);
   localparam logic [10:0] X_LO = 11'(BOX_X0);
   localparam logic [10:0] X_HI = 11'(BOX_X0 + BOX_W);

   typedef enum logic [1:0] {S_OFF, S_MENU, S_REQ, S_LOCKED} state_t;

   state_t           state_q, state_d;
   logic [1:0]       cursor_q, cursor_d;
   logic [1:0]       choice_q, choice_d;
   logic             valid_q, valid_d;
   logic             up_prev_q, dn_prev_q, sel_prev_q;
   logic [CNT_W-1:0] cnt_up_q, cnt_up_d;
   logic [CNT_W-1:0] cnt_dn_q, cnt_dn_d;
   logic             sel_edge;

   logic [10:0]      px, py;
   logic [10:0]      lx_p0, ly_p0;
   logic             hit_p0;
   logic [1:0]       opt_p0;
   logic [13:0]      addr_p0;
   logic [1:0]       option_q;
   logic [13:0]      addr_q;
   logic             hit_p1_q;
   logic             pix_p2_q;

   assign sel_edge = key_sel & ~sel_prev_q;
   assign px       = {1'b0, draw_x};
   assign py       = {1'b0, draw_y};

   // Menu FSM next state, cursor stepping with auto-repeat, choice handshake.
   always_comb begin
      state_d  = state_q;
      cursor_d = cursor_q;
      choice_d = choice_q;
      valid_d  = valid_q;
      cnt_up_d = '0;
      cnt_dn_d = '0;
      if (state_q == S_OFF) begin
         cursor_d = '0;
      end
      if (!menu_en) begin
         state_d = S_OFF;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            S_OFF: begin
               state_d  = S_MENU;
               cursor_d = '0;
            end
            S_MENU: begin
               if (sel_edge) begin
                  // select wins over a simultaneous up/down step
                  state_d  = S_REQ;
                  choice_d = cursor_q;
                  valid_d  = 1'b1;
               end else if (key_up && key_down) begin
                  // conflicting keys: no step, repeat counters stay cleared
               end else if (key_up) begin
                  if (!up_prev_q || cnt_up_q == REP_LAST) begin
                     cursor_d = cursor_q - 2'd1;
                  end else begin
                     cnt_up_d = cnt_up_q + 1'b1;
                  end
               end else if (key_down) begin
                  if (!dn_prev_q || cnt_dn_q == REP_LAST) begin
                     cursor_d = cursor_q + 2'd1;
                  end else begin
                     cnt_dn_d = cnt_dn_q + 1'b1;
                  end
               end
            end
            S_REQ: begin
               if (valid_q && choice_ready) begin
                  state_d = S_LOCKED;
                  valid_d = 1'b0;
               end
            end
            S_LOCKED: begin
            end
            default: state_d = S_OFF;
         endcase
      end
   end

   // Pixel stage 0: find which box (if any) contains the draw coordinate.
   always_comb begin
      hit_p0  = 1'b0;
      opt_p0  = option_q;
      addr_p0 = addr_q;
      lx_p0   = px - X_LO;
      ly_p0   = '0;
      for (int i = 0; i < 4; i++) begin
         if (px >= X_LO && px < X_HI &&
             py >= 11'(BOX_Y0 + i * (BOX_H + BOX_GAP)) &&
             py <  11'(BOX_Y0 + i * (BOX_H + BOX_GAP) + BOX_H)) begin
            hit_p0  = 1'b1;
            opt_p0  = 2'(i);
            ly_p0   = py - 11'(BOX_Y0 + i * (BOX_H + BOX_GAP));
            addr_p0 = 14'(ly_p0) * 14'(BOX_W) + 14'(lx_p0);
         end
      end
   end

   // Control registers: FSM, cursor, key history, repeat counters, handshake.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= S_OFF;
         cursor_q   <= '0;
         choice_q   <= '0;
         valid_q    <= 1'b0;
         up_prev_q  <= 1'b0;
         dn_prev_q  <= 1'b0;
         sel_prev_q <= 1'b0;
         cnt_up_q   <= '0;
         cnt_dn_q   <= '0;
      end else begin
         state_q    <= state_d;
         cursor_q   <= cursor_d;
         choice_q   <= choice_d;
         valid_q    <= valid_d;
         up_prev_q  <= key_up;
         dn_prev_q  <= key_down;
         sel_prev_q <= key_sel;
         cnt_up_q   <= cnt_up_d;
         cnt_dn_q   <= cnt_dn_d;
      end
   end

   // Pixel stages 1 and 2: ROM option/address, then hit aligned with ROM data.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         option_q <= '0;
         addr_q   <= '0;
         hit_p1_q <= 1'b0;
         pix_p2_q <= 1'b0;
      end else begin
         option_q <= opt_p0;
         addr_q   <= addr_p0;
         hit_p1_q <= hit_p0;
         pix_p2_q <= hit_p1_q & (state_q != S_OFF);
      end
   end

   assign option       = option_q;
   assign option_ctr   = cursor_q;
   assign read_address = addr_q;
   assign pix_in_box   = pix_p2_q;
   assign choice_valid = valid_q;
   assign choice       = choice_q;

endmodule

// File: tb/tb_option_menu_ctrl.sv
// Bench for option_menu_ctrl: cursor stepping, auto-repeat, handshake,
// reset/disable behaviour and the pixel mapping pipeline.
module tb_option_menu_ctrl;

   localparam int REP = 10;
   localparam int X0  = 245;
   localparam int Y0  = 90;
   localparam int BW  = 150;
   localparam int BH  = 60;
   localparam int GAP = 15;

   typedef struct {
      int opt;
      int addr;
      bit hit;
   } pix_t;

   logic        Clk = 1'b0;
   logic        Reset, menu_en, key_up, key_down, key_sel, choice_ready;
   logic [9:0]  draw_x, draw_y;
   logic [1:0]  option, option_ctr, choice;
   logic [13:0] read_address;
   logic        pix_in_box, choice_valid;

   int n_cmp = 0;
   int n_bad = 0;
   int ctr_q[$];
   pix_t pq[$];
   int m_opt, m_addr;

   always #5 Clk = ~Clk;

   option_menu_ctrl #(
      .BOX_W(BW), .BOX_H(BH), .BOX_X0(X0), .BOX_Y0(Y0), .BOX_GAP(GAP), .REPEAT_CYC(REP)
   ) dut (
      .Clk(Clk), .Reset(Reset), .menu_en(menu_en),
      .key_up(key_up), .key_down(key_down), .key_sel(key_sel),
      .draw_x(draw_x), .draw_y(draw_y),
      .option(option), .option_ctr(option_ctr), .read_address(read_address),
      .pix_in_box(pix_in_box), .choice_valid(choice_valid), .choice(choice),
      .choice_ready(choice_ready)
   );

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Reference box mapping derived from the box pitch arithmetic.
   function automatic void ref_pix(input int x, input int y, output bit hit,
                                   output int opt, output int addr);
      int rel;
      hit = 1'b0; opt = 0; addr = 0;
      if (x >= X0 && x < X0 + BW && y >= Y0) begin
         rel = y - Y0;
         if (rel / (BH + GAP) < 4 && rel % (BH + GAP) < BH) begin
            hit  = 1'b1;
            opt  = rel / (BH + GAP);
            addr = (rel % (BH + GAP)) * BW + (x - X0);
         end
      end
   endfunction

   task automatic test_reset();
      Reset = 1'b1; menu_en = 1'b0; key_up = 1'b0; key_down = 1'b0; key_sel = 1'b0;
      choice_ready = 1'b0; draw_x = 10'd245; draw_y = 10'd90;
      tick(); tick();
      n_cmp++; if (option_ctr !== 2'd0) begin n_bad++; $display("FAIL reset_ctr: got %0d want 0", option_ctr); end
      n_cmp++; if (option !== 2'd0) begin n_bad++; $display("FAIL reset_option: got %0d want 0", option); end
      n_cmp++; if (read_address !== 14'd0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", read_address); end
      n_cmp++; if (pix_in_box !== 1'b0) begin n_bad++; $display("FAIL reset_pix: got %0b want 0", pix_in_box); end
      n_cmp++; if (choice_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", choice_valid); end
      n_cmp++; if (choice !== 2'd0) begin n_bad++; $display("FAIL reset_choice: got %0d want 0", choice); end
      Reset = 1'b0; draw_x = 10'd0; draw_y = 10'd0;
      tick(); tick();
      n_cmp++; if (pix_in_box !== 1'b0) begin n_bad++; $display("FAIL off_pix: got %0b want 0", pix_in_box); end
   endtask

   task automatic test_wrap();
      int dirs [5] = '{1, 1, 1, 1, 0};
      int want [5] = '{1, 2, 3, 0, 3};
      int e;
      menu_en = 1'b1;
      tick();
      n_cmp++; if (option_ctr !== 2'd0) begin n_bad++; $display("FAIL menu_entry_ctr: got %0d want 0", option_ctr); end
      for (int i = 0; i < 5; i++) begin
         if (dirs[i] == 1) key_down = 1'b1; else key_up = 1'b1;
         ctr_q.push_back(want[i]);
         tick();
         e = ctr_q.pop_front();
         n_cmp++; if (option_ctr !== 2'(e)) begin n_bad++; $display("FAIL wrap_step%0d: got %0d want %0d", i, option_ctr, e); end
         key_down = 1'b0; key_up = 1'b0;
         ctr_q.push_back(want[i]);
         tick();
         e = ctr_q.pop_front();
         n_cmp++; if (option_ctr !== 2'(e)) begin n_bad++; $display("FAIL wrap_rel%0d: got %0d want %0d", i, option_ctr, e); end
      end
   endtask

   task automatic test_repeat();
      int s, e;
      s = 3;
      key_down = 1'b1;
      for (int k = 0; k < 35; k++) begin
         ctr_q.push_back((s + 1 + k / REP) % 4);
         tick();
         e = ctr_q.pop_front();
         n_cmp++; if (option_ctr !== 2'(e)) begin n_bad++; $display("FAIL repeat_hold%0d: got %0d want %0d", k, option_ctr, e); end
      end
      key_down = 1'b0;
      for (int k = 0; k < 15; k++) begin
         ctr_q.push_back((s + 4) % 4);
         tick();
         e = ctr_q.pop_front();
         n_cmp++; if (option_ctr !== 2'(e)) begin n_bad++; $display("FAIL repeat_release%0d: got %0d want %0d", k, option_ctr, e); end
      end
   endtask

   task automatic test_handshake();
      int s;
      s = 3;
      key_up = 1'b1; key_down = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         n_cmp++; if (option_ctr !== 2'(s)) begin n_bad++; $display("FAIL updown_same%0d: got %0d want %0d", k, option_ctr, s); end
      end
      key_up = 1'b0; key_down = 1'b0;
      tick();
      key_sel = 1'b1;
      tick();
      key_sel = 1'b0;
      n_cmp++; if (choice_valid !== 1'b1) begin n_bad++; $display("FAIL sel_valid: got %0b want 1", choice_valid); end
      n_cmp++; if (choice !== 2'(s)) begin n_bad++; $display("FAIL sel_choice: got %0d want %0d", choice, s); end
      for (int k = 0; k < 5; k++) begin
         key_down = (k % 2 == 0);
         tick();
         n_cmp++; if (choice_valid !== 1'b1) begin n_bad++; $display("FAIL req_hold_valid%0d: got %0b want 1", k, choice_valid); end
         n_cmp++; if (choice !== 2'(s)) begin n_bad++; $display("FAIL req_hold_choice%0d: got %0d want %0d", k, choice, s); end
         n_cmp++; if (option_ctr !== 2'(s)) begin n_bad++; $display("FAIL req_keys_ignored%0d: got %0d want %0d", k, option_ctr, s); end
      end
      key_down = 1'b0;
      choice_ready = 1'b1;
      tick();
      choice_ready = 1'b0;
      n_cmp++; if (choice_valid !== 1'b0) begin n_bad++; $display("FAIL accept_valid: got %0b want 0", choice_valid); end
      key_down = 1'b1; tick(); key_down = 1'b0; tick();
      key_up = 1'b1; tick(); key_up = 1'b0; tick();
      n_cmp++; if (option_ctr !== 2'(s)) begin n_bad++; $display("FAIL locked_ctr: got %0d want %0d", option_ctr, s); end
      key_sel = 1'b1; tick(); key_sel = 1'b0; tick();
      n_cmp++; if (choice_valid !== 1'b0) begin n_bad++; $display("FAIL locked_sel: got %0b want 0", choice_valid); end
   endtask

   task automatic test_sel_priority();
      menu_en = 1'b0;
      tick();
      n_cmp++; if (choice_valid !== 1'b0) begin n_bad++; $display("FAIL off_valid: got %0b want 0", choice_valid); end
      menu_en = 1'b1;
      tick();
      n_cmp++; if (option_ctr !== 2'd0) begin n_bad++; $display("FAIL reentry_ctr: got %0d want 0", option_ctr); end
      key_down = 1'b1; key_sel = 1'b1;
      tick();
      key_down = 1'b0; key_sel = 1'b0;
      n_cmp++; if (option_ctr !== 2'd0) begin n_bad++; $display("FAIL selwin_ctr: got %0d want 0", option_ctr); end
      n_cmp++; if (choice_valid !== 1'b1) begin n_bad++; $display("FAIL selwin_valid: got %0b want 1", choice_valid); end
      n_cmp++; if (choice !== 2'd0) begin n_bad++; $display("FAIL selwin_choice: got %0d want 0", choice); end
      choice_ready = 1'b1;
      tick();
      choice_ready = 1'b0;
      n_cmp++; if (choice_valid !== 1'b0) begin n_bad++; $display("FAIL selwin_accept: got %0b want 0", choice_valid); end
   endtask

   task automatic test_reset_mid();
      menu_en = 1'b0; tick();
      menu_en = 1'b1; tick();
      for (int k = 0; k < 2; k++) begin
         key_down = 1'b1; tick(); key_down = 1'b0; tick();
      end
      n_cmp++; if (option_ctr !== 2'd2) begin n_bad++; $display("FAIL mid_ctr: got %0d want 2", option_ctr); end
      key_sel = 1'b1; tick(); key_sel = 1'b0;
      n_cmp++; if (choice !== 2'd2 || choice_valid !== 1'b1) begin n_bad++; $display("FAIL mid_req: got v=%0b c=%0d want v=1 c=2", choice_valid, choice); end
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      n_cmp++; if (choice_valid !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid: got %0b want 0", choice_valid); end
      n_cmp++; if (option_ctr !== 2'd0) begin n_bad++; $display("FAIL rst_req_ctr: got %0d want 0", option_ctr); end
      n_cmp++; if (choice !== 2'd0) begin n_bad++; $display("FAIL rst_req_choice: got %0d want 0", choice); end
      tick();
      key_down = 1'b1; tick(); key_down = 1'b0; tick();
      n_cmp++; if (option_ctr !== 2'd1) begin n_bad++; $display("FAIL after_rst_step: got %0d want 1", option_ctr); end
      key_sel = 1'b1; tick(); key_sel = 1'b0;
      n_cmp++; if (choice !== 2'd1 || choice_valid !== 1'b1) begin n_bad++; $display("FAIL req2: got v=%0b c=%0d want v=1 c=1", choice_valid, choice); end
      menu_en = 1'b0;
      tick();
      n_cmp++; if (choice_valid !== 1'b0) begin n_bad++; $display("FAIL disable_req_valid: got %0b want 0", choice_valid); end
   endtask

   task automatic test_pixel_points();
      int xs [10] = '{245, 394, 394, 245, 244, 395, 300, 300, 246, 394};
      int ys [10] = '{ 90, 374, 314, 150, 90,  90,  165, 164,  91, 315};
      bit h; int o, a;
      pix_t e, p;
      Reset = 1'b1; menu_en = 1'b0; draw_x = 10'd0; draw_y = 10'd0;
      tick();
      Reset = 1'b0; menu_en = 1'b1;
      tick();
      m_opt = 0; m_addr = 0;
      pq.delete();
      pq.push_back('{m_opt, m_addr, 1'b0});
      for (int i = 0; i < 10; i++) begin
         draw_x = 10'(xs[i]); draw_y = 10'(ys[i]);
         ref_pix(xs[i], ys[i], h, o, a);
         if (h) begin m_opt = o; m_addr = a; end
         pq.push_back('{m_opt, m_addr, h});
         tick();
         e = pq[$];
         n_cmp++; if (option !== 2'(e.opt)) begin n_bad++; $display("FAIL pt_option(%0d,%0d): got %0d want %0d", xs[i], ys[i], option, e.opt); end
         n_cmp++; if (read_address !== 14'(e.addr)) begin n_bad++; $display("FAIL pt_addr(%0d,%0d): got %0d want %0d", xs[i], ys[i], read_address, e.addr); end
         p = pq.pop_front();
         n_cmp++; if (pix_in_box !== p.hit) begin n_bad++; $display("FAIL pt_pix%0d: got %0b want %0b", i, pix_in_box, p.hit); end
      end
      draw_x = 10'd0; draw_y = 10'd0;
      tick();
      p = pq.pop_front();
      n_cmp++; if (pix_in_box !== p.hit) begin n_bad++; $display("FAIL pt_pix_last: got %0b want %0b", pix_in_box, p.hit); end
      pq.delete();
      menu_en = 1'b0; draw_x = 10'd245; draw_y = 10'd90;
      tick();
      n_cmp++; if (read_address !== 14'd0 || option !== 2'd0) begin n_bad++; $display("FAIL off_map: got o=%0d a=%0d want o=0 a=0", option, read_address); end
      tick();
      n_cmp++; if (pix_in_box !== 1'b0) begin n_bad++; $display("FAIL off_pix_forced: got %0b want 0", pix_in_box); end
      draw_x = 10'd0; draw_y = 10'd0;
      tick();
   endtask

   task automatic test_frame_sweep();
      int rows [10] = '{0, 89, 90, 149, 150, 164, 165, 314, 374, 479};
      int cols [8]  = '{0, 244, 245, 246, 300, 393, 394, 395};
      int pts_x[$], pts_y[$];
      bit h; int o, a;
      pix_t e, p;
      foreach (rows[r]) for (int x = 0; x < 640; x++) begin pts_x.push_back(x); pts_y.push_back(rows[r]); end
      foreach (cols[c]) for (int y = 0; y < 480; y++) begin pts_x.push_back(cols[c]); pts_y.push_back(y); end
      for (int k = 0; k < 1500; k++) begin
         pts_x.push_back(int'($urandom_range(440, 200)));
         pts_y.push_back(int'($urandom_range(400, 60)));
      end
      Reset = 1'b1; menu_en = 1'b0; draw_x = 10'd0; draw_y = 10'd0;
      tick();
      Reset = 1'b0; menu_en = 1'b1;
      tick();
      m_opt = 0; m_addr = 0;
      pq.delete();
      pq.push_back('{m_opt, m_addr, 1'b0});
      for (int i = 0; i < pts_x.size(); i++) begin
         draw_x = 10'(pts_x[i]); draw_y = 10'(pts_y[i]);
         ref_pix(pts_x[i], pts_y[i], h, o, a);
         if (h) begin m_opt = o; m_addr = a; end
         pq.push_back('{m_opt, m_addr, h});
         tick();
         e = pq[$];
         n_cmp++; if (option !== 2'(e.opt)) begin n_bad++; $display("FAIL sweep_option(%0d,%0d): got %0d want %0d", pts_x[i], pts_y[i], option, e.opt); end
         n_cmp++; if (read_address !== 14'(e.addr)) begin n_bad++; $display("FAIL sweep_addr(%0d,%0d): got %0d want %0d", pts_x[i], pts_y[i], read_address, e.addr); end
         p = pq.pop_front();
         n_cmp++; if (pix_in_box !== p.hit) begin n_bad++; $display("FAIL sweep_pix%0d: got %0b want %0b", i, pix_in_box, p.hit); end
      end
      draw_x = 10'd0; draw_y = 10'd0;
      tick();
      p = pq.pop_front();
      n_cmp++; if (pix_in_box !== p.hit) begin n_bad++; $display("FAIL sweep_pix_last: got %0b want %0b", pix_in_box, p.hit); end
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_repeat();
      test_handshake();
      test_sel_priority();
      test_reset_mid();
      test_pixel_points();
      test_frame_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
